// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, redirect and memory-wait sequencing for the five-stage pipeline
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wb_ena,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_wb_ena,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wb_ena,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WC_W      = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_stall;
    logic in_abort;

    assign in_abort  = (state_q == ST_ABORT);
    assign mem_stall = mem_req & ~mem_ack & ~in_abort;
    assign load_use  = ex_is_load & ex_wb_ena & (ex_rd != 5'd0) &
                       ((id_rs1_used & (id_rs1 == ex_rd)) |
                        (id_rs2_used & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // wait_cnt counts cycles already spent waiting, including the IDLE cycle that started the access
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_ABORT;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ST_ABORT: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_err      = in_abort;
        if (rst) begin
            if (mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
            // the aborted access must not reach writeback
            if (in_abort) begin
                mem_wb_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (mem_wb_ena && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) begin
            fwd_a_sel = 2'b01;
        end else if (wb_wb_ena && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
            fwd_a_sel = 2'b10;
        end
        if (mem_wb_ena && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) begin
            fwd_b_sel = 2'b01;
        end else if (wb_wb_ena && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
            fwd_b_sel = 2'b10;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_rs1_used, id_rs2_used, ex_wb_ena, ex_is_load;
    logic          mem_wb_ena, wb_wb_ena, ex_branch_taken, mem_req, mem_ack;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int vec;
    int miss;

    int   m_wait;
    bit   m_abort;
    int   m_scnt;
    int   m_fcnt;
    logic [3:0] e_stall;
    logic [2:0] e_flush;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_wb_ena       (ex_wb_ena),
        .ex_is_load      (ex_is_load),
        .mem_rd          (mem_rd),
        .mem_wb_ena      (mem_wb_ena),
        .wb_rd           (wb_rd),
        .wb_wb_ena       (wb_wb_ena),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (mem_wb_ena && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_wb_ena && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; ex_wb_ena = 0; ex_is_load = 0;
        mem_wb_ena = 0; wb_wb_ena = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    // sample at the falling edge and compare every output with the model
    task automatic settle();
        bit lu, mstall;
        @(negedge clk);
        if (!rst) begin
            m_wait = 0; m_abort = 0; m_scnt = 0; m_fcnt = 0;
        end
        lu = ex_is_load && ex_wb_ena && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        mstall = !m_abort && mem_req && !mem_ack;
        e_stall = 4'b0000;
        e_flush = 3'b000;
        if (rst) begin
            if (mstall) begin
                e_stall = 4'b1111; e_flush = 3'b001;
            end else if (ex_branch_taken) begin
                e_flush = 3'b110;
            end else if (lu) begin
                e_stall = 4'b1100; e_flush = 3'b010;
            end
            if (m_abort) e_flush[0] = 1'b1;
        end
        chk("stalls", 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall}), 32'(e_stall));
        chk("flushes", 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 32'(e_flush));
        chk("fwd_a", 32'(fwd_a_sel), 32'(fwd_ref(ex_rs1)));
        chk("fwd_b", 32'(fwd_b_sel), 32'(fwd_ref(ex_rs2)));
        chk("mem_err", 32'(mem_err), 32'(m_abort));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    endtask

    // advance the model across the rising edge using the outputs expected this cycle
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (e_stall[3] && m_scnt < CMAX) m_scnt++;
            if (e_flush[2] && m_fcnt < CMAX) m_fcnt++;
            if (m_abort) begin
                m_abort = 0; m_wait = 0;
            end else if (m_wait == 0) begin
                if (mem_req && !mem_ack) m_wait = 1;
            end else if (mem_ack) begin
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == MT) begin
                    m_abort = 1; m_wait = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        vec = 0; miss = 0;
        m_wait = 0; m_abort = 0; m_scnt = 0; m_fcnt = 0;
        clear_inputs();
        rst = 1'b0;
        mem_req = 1; ex_branch_taken = 1; ex_is_load = 1; ex_wb_ena = 1;
        ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        settle();
        chk("rst_pc_stall", 32'(pc_stall), 0);
        chk("rst_flush", 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        tick();
        rst = 1'b1;
        clear_inputs();
        settle(); tick();

        ex_is_load = 1; ex_wb_ena = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        settle();
        chk("lu_ctrl", 32'({pc_stall, if_id_stall, id_ex_flush}), 32'(3'b111));
        chk("lu_cnt0", 32'(stall_cnt), 0);
        tick();
        clear_inputs();
        settle();
        chk("lu_cnt1", 32'(stall_cnt), 1);
        chk("lu_release", 32'(pc_stall), 0);
        tick();

        ex_is_load = 1; ex_wb_ena = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        settle(); chk("lu_x0", 32'(pc_stall), 0); tick();
        ex_rd = 5; id_rs1 = 5; id_rs1_used = 0;
        settle(); chk("lu_unused", 32'(pc_stall), 0); tick();
        clear_inputs();

        ex_branch_taken = 1;
        settle(); chk("br_flush", 32'({if_id_flush, id_ex_flush, pc_stall}), 32'(3'b110)); tick();
        clear_inputs();
        settle(); chk("br_cnt", 32'(flush_cnt), 1); tick();

        ex_branch_taken = 1; ex_is_load = 1; ex_wb_ena = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        settle();
        chk("br_lu", 32'({if_id_flush, id_ex_flush, pc_stall, if_id_stall}), 32'(4'b1100));
        tick();
        clear_inputs();

        mem_req = 1; ex_branch_taken = 1;
        for (int k = 1; k <= 4; k++) begin
            mem_ack = (k == 4);
            settle();
            if (k < 4) chk("mw_stall", 32'({pc_stall, ex_mem_stall, mem_wb_flush, if_id_flush}), 32'(4'b1110));
            else       chk("mw_release", 32'({pc_stall, ex_mem_stall, mem_wb_flush, if_id_flush}), 32'(4'b0001));
            tick();
        end
        clear_inputs();
        settle();
        chk("fl_cnt3", 32'(flush_cnt), 3);
        chk("st_sat", 32'(stall_cnt), 3);
        tick();
        ex_branch_taken = 1; settle(); tick();
        clear_inputs();
        settle(); chk("fl_sat", 32'(flush_cnt), 3); tick();

        mem_req = 1;
        for (int k = 1; k <= 5; k++) begin
            mem_ack = (k == 5);
            settle();
            if (k <= 4) chk("to_stall", 32'({pc_stall, mem_err}), 32'(2'b10));
            else        chk("to_abort", 32'({pc_stall, id_ex_stall, mem_wb_flush, mem_err}), 32'(4'b0011));
            tick();
        end
        clear_inputs();
        settle(); chk("to_idle", 32'(mem_err), 0); tick();

        ex_rs1 = 7; ex_rs2 = 7; mem_rd = 7; wb_rd = 7; mem_wb_ena = 1; wb_wb_ena = 1;
        settle(); chk("fwd_mem", 32'(fwd_a_sel), 1); tick();
        mem_wb_ena = 0;
        settle(); chk("fwd_wb", 32'(fwd_a_sel), 2); chk("fwd_wb_b", 32'(fwd_b_sel), 2); tick();
        mem_wb_ena = 1; ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
        settle(); chk("fwd_r0", 32'(fwd_a_sel), 0); tick();
        clear_inputs();

        mem_req = 1;
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        #1;
        chk("arst_stall", 32'(pc_stall), 0);
        chk("arst_cnt", 32'(stall_cnt), 0);
        settle(); tick();
        rst = 1'b1;
        settle(); chk("arst_restart", 32'(pc_stall), 1); tick();
        clear_inputs();
        settle(); tick();

        for (int i = 0; i < 3000; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rs1          = 5'($urandom_range(0, 3));
            ex_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            mem_rd          = 5'($urandom_range(0, 3));
            wb_rd           = 5'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            ex_wb_ena       = 1'($urandom_range(0, 1));
            ex_is_load      = 1'($urandom_range(0, 1));
            mem_wb_ena      = 1'($urandom_range(0, 1));
            wb_wb_ena       = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req         = 1'($urandom_range(0, 1));
            mem_ack         = ($urandom_range(0, 3) == 0);
            rst             = ($urandom_range(0, 63) != 0);
            settle();
            tick();
        end

        rst = 1'b1;
        clear_inputs();
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the five-stage miniLA pipeline. It drives the stall/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and supplies EX-stage operand forwarding selects. It resolves load-use hazards, taken-branch redirects, and multi-cycle data-memory waits with a timeout abort. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, default 16: max consecutive un-acked memory cycles before abort (≥2)
- CNT_W, default 16: width of performance counters
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- id_rs1, id_rs2  input  5  source registers of instruction in ID
- id_rs1_used, id_rs2_used  input  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  input  5  source registers of instruction in EX
- ex_rd  input  5  destination of EX instruction; ex_wb_ena input 1; ex_is_load input 1
- mem_rd  input  5; mem_wb_ena  input  1  MEM-stage writeback info
- wb_rd  input  5; wb_wb_ena  input  1  WB-stage writeback info
- ex_branch_taken  input  1  EX resolved a redirect (branch taken / jump)
- mem_req  input  1  MEM-stage instruction accesses DRAM
- mem_ack  input  1  DRAM completes access this cycle
- pc_stall, if_id_stall, ex_mem_stall  output  1  hold register contents
- id_ex_stall  output  1  hold ID/EX
- if_id_flush, id_ex_flush, mem_wb_flush  output  1  load bubble (zero control) into register
- fwd_a_sel, fwd_b_sel  output  2  00 regfile, 01 MEM result, 10 WB result
- mem_err  output  1  one-cycle pulse on memory timeout abort
- stall_cnt, flush_cnt  output  CNT_W  saturating counters

## Operation
- Hazard terms (combinational): load_use = ex_is_load & ex_wb_ena & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)); mem_stall = mem_req & ~mem_ack & state==WAIT_OK (below).
- Priority, highest first:
  1. mem_stall: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall =1; mem_wb_flush=1; all other flushes 0. A branch in EX is held and acted on when the stall releases.
  2. ex_branch_taken: if_id_flush=1 and id_ex_flush=1; no stalls.
  3. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- Otherwise all stall/flush outputs are 0.
- Forwarding (independent of priority): fwd_a_sel=01 if mem_wb_ena & mem_rd≠0 & mem_rd==ex_rs1; else 10 if wb_wb_ena & wb_rd≠0 & wb_rd==ex_rs1; else 00. MEM beats WB. fwd_b_sel is identical using ex_rs2.
- Memory FSM, states IDLE, WAIT, ABORT; wait_cnt is a counter of width clog2(MEM_TIMEOUT)+1:
  - IDLE: mem_stall is enabled. If mem_req & ~mem_ack: go to WAIT, wait_cnt=1.
  - WAIT: if mem_ack, go to IDLE and clear wait_cnt. Else, if wait_cnt==MEM_TIMEOUT-1, go to ABORT; otherwise increment wait_cnt.
  - ABORT, one cycle: mem_stall is forced 0, mem_wb_flush=1 to drop the access, mem_err=1. Go to IDLE.
  - WAIT_OK means state≠ABORT.
- Counters: stall_cnt increments by 1 each cycle pc_stall=1. flush_cnt increments by 1 each cycle if_id_flush=1 from a branch. Both saturate at 2^CNT_W-1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, wait_cnt=0, counters=0, mem_err=0. All stall/flush outputs are 0 while rst is low, regardless of inputs.
- Stall/flush/forward outputs are combinational, with zero latency from inputs. Pipeline registers sample them at the same clk edge.
- load_use asserts for exactly one cycle: the load leaves EX on the next edge. If mem_stall coincides, load_use is masked and re-evaluated after release.
- Memory access with ack on the k-th cycle (k<MEM_TIMEOUT): stall is asserted for k-1 cycles.
- No ack: stall for MEM_TIMEOUT cycles (IDLE + MEM_TIMEOUT-1 WAIT), then one ABORT cycle with mem_err=1.
- mem_ack in the same cycle as entering ABORT is ignored.
- A reset assertion mid-WAIT returns to IDLE immediately; counters clear.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cnt 0→1.
- ex_rd=0 with a matching load -> no stall. id_rs1_used=0 -> no stall.
- Branch: ex_branch_taken=1 -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt +1. Branch concurrent with load_use -> branch flush only.
- Memory wait: mem_req=1, mem_ack rising on the 4th cycle -> 3 stall cycles with mem_wb_flush=1, then normal. Branch present during the wait is flushed only after release.
- Timeout (MEM_TIMEOUT=4): mem_req=1, ack never -> 4 stall cycles, then ABORT with mem_err=1 and stalls 0, then IDLE.
- Forwarding: mem_rd=wb_rd=ex_rs1=7, both wb_ena=1 -> fwd_a_sel=01. Clear mem_wb_ena -> 10. Register 0 -> 00. Counter saturation with CNT_W=2 holds at 3.
